// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    // Mult/div sequencing states.
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } md_state_t;

    // Default register-address width of the MIPS register file.
    localparam int REG_AW_DEF = 5;

    // $zero never carries a real dependency.
    localparam int ZERO_REG = 0;

endpackage : pipe_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Count enabled cycles, sticking at the maximum value instead of wrapping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule : sat_counter

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use
// interlock, taken-branch flush, mult/div HI/LO interlock and a stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_is_md,
    input  logic              id_reads_hilo,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_branch_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              md_start,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CNT_W = $clog2(MD_LATENCY + 1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] md_cnt, md_cnt_next;
    logic             load_use;
    logic             md_hz;

    // Hazard detection: a load writing a register the ID instruction reads,
    // or any HI/LO access while the mult/div unit is still working.
    always_comb begin
        load_use = ex_mem_read
                 && (ex_rt != REG_AW'(ZERO_REG))
                 && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        md_hz    = (state == MD_WAIT) && (id_reads_hilo || id_is_md);
    end

    // Pipeline control: branch redirect beats stalls, stalls beat normal flow;
    // reset forces the free-running defaults.
    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        if (!reset) begin
            if (ex_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use || md_hz) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                md_start    = id_is_md && (state == RUN);
            end
        end
    end

    assign md_busy = (state == MD_WAIT);

    // Mult/div sequencer next state: count down the unit latency after a launch.
    always_comb begin
        state_next  = state;
        md_cnt_next = md_cnt;
        case (state)
            RUN: begin
                if (md_start) begin
                    state_next  = MD_WAIT;
                    md_cnt_next = CNT_W'(MD_LATENCY);
                end
            end
            MD_WAIT: begin
                if (md_cnt <= CNT_W'(1)) begin
                    state_next  = RUN;
                    md_cnt_next = '0;
                end else begin
                    md_cnt_next = md_cnt - 1'b1;
                end
            end
            default: begin
                state_next  = RUN;
                md_cnt_next = '0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any wait in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= md_cnt_next;
        end
    end

    sat_counter #(
        .W(PERF_W)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .en    (!pc_we),
        .clear (1'b0),
        .count (stall_cycles)
    );

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: table-driven single-cycle vectors,
// hand sequences for mult/div, async reset and counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int MD_LATENCY = 4;
    localparam int REG_AW     = 5;
    localparam int PERF_W     = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
    logic              id_uses_rt, id_is_md, id_reads_hilo, ex_mem_read, ex_branch_taken;
    logic              pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy;
    logic [PERF_W-1:0] stall_cycles;

    pipe_hazard_ctrl #(
        .MD_LATENCY(MD_LATENCY),
        .REG_AW    (REG_AW),
        .PERF_W    (PERF_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_is_md       (id_is_md),
        .id_reads_hilo  (id_reads_hilo),
        .ex_mem_read    (ex_mem_read),
        .ex_rt          (ex_rt),
        .ex_branch_taken(ex_branch_taken),
        .pc_we          (pc_we),
        .ifid_we        (ifid_we),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .md_start       (md_start),
        .md_busy        (md_busy),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    // Expected outputs packed as {pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy}.
    localparam logic [5:0] E_RUN   = 6'b110000;
    localparam logic [5:0] E_LU    = 6'b000100;
    localparam logic [5:0] E_BR    = 6'b111100;
    localparam logic [5:0] E_START = 6'b110010;
    localparam logic [5:0] E_MDHZ  = 6'b000101;

    typedef struct {
        string             name;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              uses_rt;
        logic              is_md;
        logic              hilo;
        logic              mem_read;
        logic [REG_AW-1:0] ex_rt;
        logic              br;
        logic [5:0]        exp;
    } vec_t;

    typedef struct {
        string             name;
        logic [5:0]        outs;
        logic [PERF_W-1:0] stall;
    } exp_t;

    exp_t              sb[$];
    vec_t              vecs[$];
    int                checks = 0;
    int                errors = 0;
    logic [PERF_W-1:0] exp_stall = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy};
    endfunction

    function automatic vec_t mk(input string name, input int rs, input int rt, input bit uses_rt,
                                input bit is_md, input bit hilo, input bit mem_read,
                                input int exr, input bit br, input logic [5:0] exp);
        vec_t v;
        v.name = name; v.rs = REG_AW'(rs); v.rt = REG_AW'(rt); v.uses_rt = uses_rt;
        v.is_md = is_md; v.hilo = hilo; v.mem_read = mem_read; v.ex_rt = REG_AW'(exr);
        v.br = br; v.exp = exp;
        return v;
    endfunction

    // Apply one vector and record what the DUT should produce this cycle.
    task automatic drive(input vec_t v);
        exp_t e;
        id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_is_md = v.is_md;
        id_reads_hilo = v.hilo; ex_mem_read = v.mem_read; ex_rt = v.ex_rt;
        ex_branch_taken = v.br;
        e.name = v.name; e.outs = v.exp; e.stall = exp_stall;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare; advance the stall-count model.
    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            check({e.name, " outs"}, 32'(outs()), 32'(e.outs));
            check({e.name, " stall"}, 32'(stall_cycles), 32'(e.stall));
            if (!e.outs[5] && (exp_stall != '1)) exp_stall++;
        end
    endtask

    task automatic step(input vec_t v);
        drive(v);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously (away from the edge) with a hazard pending,
    // check the forced defaults, release just after the next edge.
    task automatic do_reset(input string name);
        exp_t e;
        #2;
        reset = 1'b1;
        exp_stall = '0;
        e.name = name; e.outs = E_RUN; e.stall = '0;
        sb.push_back(e);
        #1;
        compare();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        // Load-use hazard presented during reset: outputs must still be the defaults.
        drive(mk("reset_defaults", 5, 0, 0, 0, 1, 1, 5, 0, E_RUN));
        #1;
        compare();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        vecs.push_back(mk("idle",            0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        vecs.push_back(mk("lu_rs5",          5, 2, 0, 0, 0, 1, 5, 0, E_LU));
        vecs.push_back(mk("after_lu",        5, 2, 0, 0, 0, 0, 0, 0, E_RUN));
        vecs.push_back(mk("lw_zero",         0, 3, 1, 0, 0, 1, 0, 0, E_RUN));
        vecs.push_back(mk("rt_unused",       1, 7, 0, 0, 0, 1, 7, 0, E_RUN));
        vecs.push_back(mk("lu_rt7",          1, 7, 1, 0, 0, 1, 7, 0, E_LU));
        vecs.push_back(mk("lw_no_match",     3, 4, 1, 0, 0, 1, 9, 0, E_RUN));
        vecs.push_back(mk("no_load",         5, 5, 1, 0, 0, 0, 5, 0, E_RUN));
        vecs.push_back(mk("branch",          0, 0, 0, 0, 0, 0, 0, 1, E_BR));
        vecs.push_back(mk("branch_lu_md",    5, 0, 0, 1, 0, 1, 5, 1, E_BR));
        vecs.push_back(mk("after_branch_md", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        vecs.push_back(mk("hilo_in_run",     0, 0, 0, 0, 1, 0, 0, 0, E_RUN));
        foreach (vecs[i]) step(vecs[i]);

        // Mult then dependent mfhi: busy and stalled for MD_LATENCY cycles, then issues.
        step(mk("mult_start", 8, 9, 1, 1, 0, 0, 0, 0, E_START));
        for (int i = 0; i < MD_LATENCY; i++) step(mk($sformatf("mfhi_wait%0d", i), 0, 0, 0, 0, 1, 0, 0, 0, E_MDHZ));
        step(mk("mfhi_issue", 0, 0, 0, 0, 1, 0, 0, 0, E_RUN));
        step(mk("idle_after_md", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Branch during MD_WAIT flushes but does not cut the wait short.
        step(mk("mult_start2", 8, 9, 1, 1, 0, 0, 0, 0, E_START));
        step(mk("br_in_wait", 0, 0, 0, 1, 1, 0, 0, 1, 6'b111101));
        for (int i = 1; i < MD_LATENCY; i++) step(mk($sformatf("div_wait%0d", i), 0, 0, 0, 1, 0, 0, 0, 0, E_MDHZ));
        step(mk("div_issue", 0, 0, 0, 1, 0, 0, 0, 0, E_START));
        for (int i = 0; i < MD_LATENCY; i++) step(mk($sformatf("idle_wait%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 6'b110001));
        step(mk("idle_md_done", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Async reset while md_cnt==2 aborts the wait; mfhi then issues at once.
        step(mk("mult_start3", 8, 9, 1, 1, 0, 0, 0, 0, E_START));
        step(mk("mfhi_cnt4", 0, 0, 0, 0, 1, 0, 0, 0, E_MDHZ));
        step(mk("mfhi_cnt3", 0, 0, 0, 0, 1, 0, 0, 0, E_MDHZ));
        do_reset("reset_in_wait");
        step(mk("mfhi_after_reset", 0, 0, 0, 0, 1, 0, 0, 0, E_RUN));
        step(mk("idle_after_reset", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        // Continuous load-use stall: counter must stick at all-ones without wrapping.
        do_reset("reset_before_sat");
        drive(mk("sat_hold", 5, 0, 0, 0, 0, 1, 5, 0, E_LU));
        void'(sb.pop_front());
        repeat ((1 << PERF_W) - 2) @(posedge clk);
        #1;
        check("stall_near_max", 32'(stall_cycles), 32'((1 << PERF_W) - 2));
        check("sat_stalled_outs", 32'(outs()), 32'(E_LU));
        repeat (5) @(posedge clk);
        #1;
        check("stall_saturated", 32'(stall_cycles), 32'((1 << PERF_W) - 1));
        exp_stall = '1;
        step(mk("sat_release", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
        step(mk("sat_one_more", 5, 0, 0, 0, 0, 1, 5, 0, E_LU));
        step(mk("sat_hold_max", 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
